// File: rtl/dut_arb_pkg.sv
// Shared types and helpers for the frame-aware round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE = no frame open, LOCKED = frame open)
//   rr_next     : round-robin pointer increment, wrapping at num_if
package dut_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // num_if is always a power of two here, so the modulo reduces to a wrap.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_if);
    return (ptr + 1) % num_if;
  endfunction

endpackage

// File: rtl/dut_rr_picker.sv
// Combinational round-robin picker.
//   req     in  NUM_IF    request vector
//   ptr     in  ID_WIDTH  highest-priority index for this pick
//   gnt_id  out ID_WIDTH  first requesting index at or after ptr (mod NUM_IF)
//   gnt_any out 1         any request present (gnt_id is don't-care otherwise)
module dut_rr_picker #(
  parameter int ID_WIDTH = 2,
  parameter int NUM_IF   = 4
) (
  input  logic [NUM_IF-1:0]   req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic [ID_WIDTH-1:0] gnt_id,
  output logic                gnt_any
);

  logic [2*NUM_IF-1:0] dbl;
  logic [NUM_IF-1:0]   rot;
  logic [ID_WIDTH-1:0] idx;

  // Rotate so ptr lands on bit 0, pick the lowest set bit, then un-rotate
  // by adding ptr back (wraps naturally in ID_WIDTH bits).
  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_IF-1:0];
    idx = '0;
    for (int i = NUM_IF - 1; i >= 0; i--) begin
      if (rot[i]) idx = ID_WIDTH'(i);
    end
  end

  assign gnt_id  = idx + ptr;
  assign gnt_any = |req;

endmodule

// File: rtl/dut_frame_arbiter.sv
// Frame-aware round-robin arbiter feeding the 18x18 math wrapper.
// Merges NUM_IF valid/ready beat streams into one registered output stream
// tagged with the source ID. Once a frame's first beat is accepted the grant
// stays with that source until its last beat, so frames never interleave.
//   clk, nreset        clock, asynchronous active-low reset
//   in_data            NUM_IF*DATA_WIDTH, interface i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_last/in_valid   per-interface frame-last / beat-valid
//   in_ready           per-interface accept, one-hot or zero
//   out_data*          registered arbitrated beat, source id, last, valid
//   out_data_ready     downstream accept
module dut_frame_arbiter
  import dut_arb_pkg::*;
#(
  parameter int  DATA_WIDTH            = 36,  // >= 36: carries two 18-bit operands
  parameter int  IN_INTERFACE_ID_WIDTH = 2,
  localparam int NUM_IF                = 2 ** IN_INTERFACE_ID_WIDTH,
  localparam int ID_WIDTH              = IN_INTERFACE_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         nreset,
  input  logic [NUM_IF*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IF-1:0]            in_last,
  input  logic [NUM_IF-1:0]            in_valid,
  output logic [NUM_IF-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [ID_WIDTH-1:0]          out_data_source_id,
  output logic                         out_data_last,
  output logic                         out_data_valid,
  input  logic                         out_data_ready
);

  arb_state_e            state, state_nxt;
  logic [ID_WIDTH-1:0]   owner, rr_ptr, pick_id, sel;
  logic                  pick_any, load_en, xfer, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  dut_rr_picker #(.ID_WIDTH(ID_WIDTH), .NUM_IF(NUM_IF)) u_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_id  (pick_id),
    .gnt_any (pick_any)
  );

  // Output register can take a new beat when empty or draining this cycle.
  assign load_en  = !out_data_valid || out_data_ready;
  assign sel      = (state == ARB_LOCKED) ? owner : pick_id;
  assign sel_data = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last = in_last[sel];
  assign xfer     = in_valid[sel] && in_ready[sel];

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ARB_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:   if (xfer && !sel_last) state_nxt = ARB_LOCKED;
      ARB_LOCKED: if (xfer &&  sel_last) state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // Output decode: while LOCKED the owner keeps ready even if it drops valid,
  // which keeps everyone else blocked until its last beat. Gated by nreset so
  // no source sees a beat accepted while the arbiter is held in reset.
  always_comb begin
    in_ready = '0;
    if (nreset && load_en && (state == ARB_LOCKED || pick_any)) in_ready[sel] = 1'b1;
  end

  // Owner is captured on a frame's first beat; the pointer advances past the
  // source whose frame just closed.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      owner  <= '0;
      rr_ptr <= '0;
    end else if (xfer) begin
      if (state == ARB_IDLE && !sel_last) owner <= sel;
      if (sel_last) rr_ptr <= ID_WIDTH'(rr_next(32'(sel), NUM_IF));
    end
  end

  // Output register: refill on xfer, otherwise drain on ready; payload holds.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_data           <= '0;
      out_data_source_id <= '0;
      out_data_last      <= 1'b0;
      out_data_valid     <= 1'b0;
    end else if (xfer) begin
      out_data           <= sel_data;
      out_data_source_id <= sel;
      out_data_last      <= sel_last;
      out_data_valid     <= 1'b1;
    end else if (out_data_ready) begin
      out_data_valid     <= 1'b0;
    end
  end

endmodule
